// File: rtl/fetch_unit_pkg.sv
// Shared constants for the instruction-fetch stage.
package fetch_unit_pkg;

    localparam int          DEF_XLEN     = 32;
    localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] INSTR_NOP    = 32'h0000_0013;
    localparam int          PC_INCREMENT = 4;

    // Clears the two byte-offset bits so a fetch address is always word aligned.
    function automatic logic [DEF_XLEN-1:0] alignPc(input logic [DEF_XLEN-1:0] pc);
        return pc & ~DEF_XLEN'(3);
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with clear; used both for the {pc, instr} buffer and for the
// queue of PCs whose memory responses are still pending.
module fetch_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 2,
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    input  logic             i_clear,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty,
    output logic [CW-1:0]    o_count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wrPtr;
    logic [PW-1:0]    r_rdPtr;
    logic [CW-1:0]    r_count;
    logic             w_doPush;
    logic             w_doPop;

    // A push into a full FIFO is only allowed when the head leaves in the same cycle.
    always_comb begin
        w_doPop  = i_pop & ~o_empty;
        w_doPush = i_push & (~o_full | w_doPop);
    end

    // Storage, pointers and occupancy; clear empties the FIFO without touching storage.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_clear) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_doPush) begin
                r_mem[r_wrPtr] <= i_data;
                r_wrPtr        <= r_wrPtr + PW'(1);
            end
            if (w_doPop) begin
                r_rdPtr <= r_rdPtr + PW'(1);
            end
            if (w_doPush && !w_doPop) begin
                r_count <= r_count + CW'(1);
            end else if (!w_doPush && w_doPop) begin
                r_count <= r_count - CW'(1);
            end
        end
    end

    // Head entry and status flags straight from the registers.
    always_comb begin
        o_data  = r_mem[r_rdPtr];
        o_full  = (r_count == CW'(DEPTH));
        o_empty = (r_count == '0);
        o_count = r_count;
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues word requests to instruction
// memory, buffers returned words with their PCs and hands them to decode.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int             XLEN            = DEF_XLEN,
    parameter logic [XLEN-1:0] RESET_PC       = XLEN'(DEF_RESET_PC),
    parameter int             FIFO_DEPTH      = 2,
    parameter int             MAX_OUTSTANDING = 2
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    output logic            o_imem_req,
    output logic [XLEN-1:0] o_imem_addr,
    input  logic            i_imem_gnt,
    input  logic            i_imem_rvalid,
    input  logic [XLEN-1:0] i_imem_rdata,
    output logic            o_valid,
    output logic [XLEN-1:0] o_instr,
    output logic [XLEN-1:0] o_pc,
    input  logic            i_ready,
    input  logic            i_redirect,
    input  logic [XLEN-1:0] i_redirect_pc
);

    localparam int OW  = $clog2(MAX_OUTSTANDING + 1);
    localparam int FCW = $clog2(FIFO_DEPTH + 1);
    localparam int SW  = $clog2(FIFO_DEPTH + MAX_OUTSTANDING + 1) + 1;

    logic [XLEN-1:0]   r_fetchPc;
    logic [OW-1:0]     r_outstanding;
    logic [OW-1:0]     r_discard;

    logic              w_req;
    logic              w_grant;
    logic              w_respDrop;
    logic              w_respPush;
    logic              w_pop;
    logic [XLEN-1:0]   w_reqPc;
    logic [2*XLEN-1:0] w_head;
    logic              w_fifoFull;
    logic              w_fifoEmpty;
    logic [FCW-1:0]    w_fifoCount;
    logic              w_pcqFull;
    logic              w_pcqEmpty;
    logic [OW-1:0]     w_pcqCount;

    // Issue and handshake decisions; buffer space is reserved at grant time.
    always_comb begin
        w_req = i_rst_n & ~i_redirect
              & ((SW'(r_outstanding) + SW'(w_fifoCount)) < SW'(FIFO_DEPTH))
              & (r_outstanding < OW'(MAX_OUTSTANDING))
              & (r_discard == '0);
        w_grant     = w_req & i_imem_gnt;
        w_respDrop  = i_imem_rvalid & (i_redirect | (r_discard != '0));
        w_respPush  = i_imem_rvalid & ~w_respDrop;
        o_valid     = i_rst_n & ~w_fifoEmpty;
        w_pop       = o_valid & i_ready & ~i_redirect;
        o_imem_req  = w_req;
        o_imem_addr = r_fetchPc;
        o_pc        = w_head[2*XLEN-1:XLEN];
        o_instr     = w_head[XLEN-1:0];
    end

    // Fetch PC: restart on redirect, otherwise step one word per granted request.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_fetchPc <= RESET_PC;
        end else if (i_redirect) begin
            r_fetchPc <= i_redirect_pc & ~XLEN'(3);
        end else if (w_grant) begin
            r_fetchPc <= r_fetchPc + XLEN'(PC_INCREMENT);
        end
    end

    // In-flight and to-be-dropped response counters; flushed requests stay outstanding until answered.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_outstanding <= '0;
            r_discard     <= '0;
        end else begin
            r_outstanding <= r_outstanding + OW'(w_grant) - OW'(i_imem_rvalid);
            if (i_redirect) begin
                r_discard <= r_outstanding - OW'(i_imem_rvalid);
            end else if (i_imem_rvalid && (r_discard != '0)) begin
                r_discard <= r_discard - OW'(1);
            end
        end
    end

    fetch_fifo #(
        .WIDTH (XLEN),
        .DEPTH (MAX_OUTSTANDING)
    ) u_pcQueue (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_push  (w_grant),
        .i_data  (r_fetchPc),
        .i_pop   (i_imem_rvalid),
        .i_clear (1'b0),
        .o_data  (w_reqPc),
        .o_full  (w_pcqFull),
        .o_empty (w_pcqEmpty),
        .o_count (w_pcqCount)
    );

    fetch_fifo #(
        .WIDTH (2 * XLEN),
        .DEPTH (FIFO_DEPTH)
    ) u_instrBuf (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_push  (w_respPush),
        .i_data  ({w_reqPc, i_imem_rdata}),
        .i_pop   (w_pop),
        .i_clear (i_redirect),
        .o_data  (w_head),
        .o_full  (w_fifoFull),
        .o_empty (w_fifoEmpty),
        .o_count (w_fifoCount)
    );

    a_noOrphanResp: assert property (@(posedge i_clk) disable iff (!i_rst_n)
        i_imem_rvalid |-> (r_outstanding != '0));
    a_pcqTracksCount: assert property (@(posedge i_clk) disable iff (!i_rst_n)
        w_pcqCount == r_outstanding);
    a_pcqNoOverflow: assert property (@(posedge i_clk) disable iff (!i_rst_n)
        w_grant |-> !w_pcqFull);
    a_pcqNoUnderflow: assert property (@(posedge i_clk) disable iff (!i_rst_n)
        i_imem_rvalid |-> !w_pcqEmpty);
    a_bufNoOverflow: assert property (@(posedge i_clk) disable iff (!i_rst_n)
        w_respPush |-> (!w_fifoFull || w_pop));
    a_discardBound: assert property (@(posedge i_clk) disable iff (!i_rst_n)
        r_discard <= r_outstanding);

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit with an in-order memory responder.
module tb_fetch_unit;

    logic        clk;
    logic        rstN;
    logic        imemReq;
    logic [31:0] imemAddr;
    logic        imemGnt;
    logic        imemRvalid;
    logic [31:0] imemRdata;
    logic        validOut;
    logic [31:0] instrOut;
    logic [31:0] pcOut;
    logic        readyIn;
    logic        redirect;
    logic [31:0] redirectPc;

    int          compared;
    int          mismatched;
    int          grantCount;
    int          respBudget;
    logic [31:0] pendingQ [$];
    logic [31:0] acceptedPc [$];
    logic [31:0] acceptedInstr [$];

    fetch_unit dut (
        .i_clk         (clk),
        .i_rst_n       (rstN),
        .o_imem_req    (imemReq),
        .o_imem_addr   (imemAddr),
        .i_imem_gnt    (imemGnt),
        .i_imem_rvalid (imemRvalid),
        .i_imem_rdata  (imemRdata),
        .o_valid       (validOut),
        .o_instr       (instrOut),
        .o_pc          (pcOut),
        .i_ready       (readyIn),
        .i_redirect    (redirect),
        .i_redirect_pc (redirectPc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] instrOf(input logic [31:0] a);
        return a ^ 32'h5A5A_0013;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic ready, input logic redir, input logic [31:0] redirPc, input logic gnt);
        readyIn    = ready;
        redirect   = redir;
        redirectPc = redirPc;
        imemGnt    = gnt;
    endtask

    // One clock: record handshakes before the edge, then update the memory model.
    task automatic stepCycle();
        logic        sawGrant;
        logic        sawResp;
        logic [31:0] grantAddr;
        #1;
        sawGrant  = imemReq && imemGnt;
        grantAddr = imemAddr;
        sawResp   = imemRvalid;
        if (validOut && readyIn && !redirect) begin
            acceptedPc.push_back(pcOut);
            acceptedInstr.push_back(instrOut);
        end
        @(posedge clk);
        #1;
        if (!rstN) begin
            pendingQ.delete();
        end else begin
            if (sawResp && pendingQ.size() > 0) void'(pendingQ.pop_front());
            if (sawGrant) begin
                pendingQ.push_back(grantAddr);
                grantCount++;
            end
        end
        if (rstN && respBudget > 0 && pendingQ.size() > 0) begin
            imemRvalid = 1'b1;
            imemRdata  = instrOf(pendingQ[0]);
            respBudget--;
        end else begin
            imemRvalid = 1'b0;
            imemRdata  = '0;
        end
        #1;
    endtask

    task automatic clearRecords();
        acceptedPc.delete();
        acceptedInstr.delete();
        grantCount = 0;
    endtask

    task automatic resetDut();
        rstN = 1'b0;
        stepCycle();
        stepCycle();
    endtask

    task automatic releaseReset();
        rstN = 1'b1;
        clearRecords();
    endtask

    task automatic waitAccepted(input string tag, input int n, input int maxCycles);
        for (int c = 0; c < maxCycles && acceptedPc.size() < n; c++) stepCycle();
        checkOutput(tag, 32'(acceptedPc.size() >= n), 32'd1);
    endtask

    task automatic waitGrants(input string tag, input int n, input int maxCycles);
        for (int c = 0; c < maxCycles && grantCount < n; c++) stepCycle();
        checkOutput(tag, 32'(grantCount >= n), 32'd1);
    endtask

    task automatic waitReq(input string tag, input int maxCycles);
        for (int c = 0; c < maxCycles && !imemReq; c++) stepCycle();
        checkOutput(tag, 32'(imemReq), 32'd1);
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        grantCount = 0;
        respBudget = 0;
        rstN       = 1'b0;
        imemRvalid = 1'b0;
        imemRdata  = '0;
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);

        $display("[TB] reset state and streaming fetch");
        respBudget = 1000;
        resetDut();
        #1;
        checkOutput("rst_req", 32'(imemReq), 32'd0);
        checkOutput("rst_valid", 32'(validOut), 32'd0);
        checkOutput("rst_pc", pcOut, 32'h0);
        checkOutput("rst_instr", instrOut, 32'h0);
        checkOutput("rst_addr", imemAddr, 32'h0);
        releaseReset();
        #1;
        checkOutput("t1_firstReq", 32'(imemReq), 32'd1);
        stepCycle();
        checkOutput("t1_validLat1", 32'(validOut), 32'd0);
        stepCycle();
        checkOutput("t1_validLat2", 32'(validOut), 32'd1);
        waitAccepted("t1_timeout", 6, 40);
        for (int i = 0; i < 6; i++) begin
            checkOutput($sformatf("t1_pc%0d", i), acceptedPc[i], 32'(i * 4));
            checkOutput($sformatf("t1_instr%0d", i), acceptedInstr[i], instrOf(32'(i * 4)));
        end

        $display("[TB] decode stall fills the buffer");
        resetDut();
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
        releaseReset();
        for (int i = 0; i < 10; i++) stepCycle();
        checkOutput("t2_grants", 32'(grantCount), 32'd2);
        checkOutput("t2_req", 32'(imemReq), 32'd0);
        checkOutput("t2_valid", 32'(validOut), 32'd1);
        checkOutput("t2_headPc", pcOut, 32'h0);
        checkOutput("t2_headInstr", instrOut, instrOf(32'h0));
        readyIn = 1'b1;
        waitAccepted("t2_timeout", 3, 30);
        checkOutput("t2_pc0", acceptedPc[0], 32'h0);
        checkOutput("t2_pc1", acceptedPc[1], 32'h4);
        checkOutput("t2_pc2", acceptedPc[2], 32'h8);
        checkOutput("t2_instr1", acceptedInstr[1], instrOf(32'h4));

        $display("[TB] redirect with two requests in flight");
        resetDut();
        respBudget = 2;
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);
        releaseReset();
        waitGrants("t3_grantTimeout", 4, 30);
        checkOutput("t3_accepted", 32'(acceptedPc.size()), 32'd2);
        checkOutput("t3_reqBlocked", 32'(imemReq), 32'd0);
        applyStimulus(1'b1, 1'b1, 32'h0000_0103, 1'b1);
        #1;
        checkOutput("t3_reqSuppressed", 32'(imemReq), 32'd0);
        stepCycle();
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);
        respBudget = 1000;
        acceptedPc.delete();
        acceptedInstr.delete();
        checkOutput("t3_flushedValid", 32'(validOut), 32'd0);
        waitReq("t3_reqTimeout", 10);
        checkOutput("t3_newAddr", imemAddr, 32'h0000_0100);
        waitAccepted("t3_timeout", 1, 20);
        checkOutput("t3_firstPc", acceptedPc[0], 32'h0000_0100);
        checkOutput("t3_firstInstr", acceptedInstr[0], instrOf(32'h0000_0100));

        $display("[TB] redirect colliding with a response, then a second redirect");
        resetDut();
        respBudget = 0;
        applyStimulus(1'b1, 1'b1, 32'h0000_0010, 1'b1);
        releaseReset();
        stepCycle();
        redirect = 1'b0;
        waitGrants("t4_grantTimeout", 2, 10);
        checkOutput("t4_firstGrant", pendingQ[0], 32'h0000_0010);
        respBudget = 2;
        stepCycle();
        checkOutput("t4_respArrives", 32'(imemRvalid), 32'd1);
        applyStimulus(1'b1, 1'b1, 32'h0000_0180, 1'b1);
        #1;
        checkOutput("t4_reqSuppressed", 32'(imemReq), 32'd0);
        stepCycle();
        checkOutput("t4_validAfterR1", 32'(validOut), 32'd0);
        redirectPc = 32'h0000_0200;
        stepCycle();
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);
        respBudget = 1000;
        acceptedPc.delete();
        acceptedInstr.delete();
        #1;
        checkOutput("t4_validAfterR2", 32'(validOut), 32'd0);
        checkOutput("t4_reqResumed", 32'(imemReq), 32'd1);
        checkOutput("t4_newAddr", imemAddr, 32'h0000_0200);
        waitAccepted("t4_timeout", 1, 20);
        checkOutput("t4_firstPc", acceptedPc[0], 32'h0000_0200);
        checkOutput("t4_firstInstr", acceptedInstr[0], instrOf(32'h0000_0200));

        $display("[TB] grant withheld, then PC wrap");
        resetDut();
        respBudget = 1000;
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b0);
        releaseReset();
        for (int i = 0; i < 5; i++) begin
            #1;
            checkOutput($sformatf("t5_req%0d", i), 32'(imemReq), 32'd1);
            checkOutput($sformatf("t5_addr%0d", i), imemAddr, 32'h0);
            stepCycle();
        end
        imemGnt = 1'b1;
        stepCycle();
        imemGnt = 1'b0;
        checkOutput("t5_stepAddr", imemAddr, 32'h4);
        applyStimulus(1'b1, 1'b1, 32'hFFFF_FFFE, 1'b0);
        stepCycle();
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b0);
        acceptedPc.delete();
        acceptedInstr.delete();
        waitReq("t5_reqTimeout", 10);
        checkOutput("t5_alignedAddr", imemAddr, 32'hFFFF_FFFC);
        imemGnt = 1'b1;
        stepCycle();
        imemGnt = 1'b0;
        checkOutput("t5_wrapAddr", imemAddr, 32'h0);
        waitAccepted("t5_timeout", 1, 20);
        checkOutput("t5_wrapPc", acceptedPc[0], 32'hFFFF_FFFC);

        $display("[TB] reset with buffered and in-flight work");
        resetDut();
        respBudget = 1;
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
        releaseReset();
        waitGrants("t6_grantTimeout", 2, 10);
        stepCycle();
        stepCycle();
        checkOutput("t6_validBefore", 32'(validOut), 32'd1);
        checkOutput("t6_pendingBefore", 32'(pendingQ.size()), 32'd1);
        rstN = 1'b0;
        #1;
        checkOutput("t6_validInReset", 32'(validOut), 32'd0);
        checkOutput("t6_reqInReset", 32'(imemReq), 32'd0);
        stepCycle();
        checkOutput("t6_validAfter", 32'(validOut), 32'd0);
        checkOutput("t6_pcAfter", pcOut, 32'h0);
        respBudget = 1000;
        readyIn = 1'b1;
        releaseReset();
        #1;
        checkOutput("t6_restartReq", 32'(imemReq), 32'd1);
        checkOutput("t6_restartAddr", imemAddr, 32'h0);
        waitAccepted("t6_timeout", 2, 20);
        checkOutput("t6_firstPc", acceptedPc[0], 32'h0);
        checkOutput("t6_secondPc", acceptedPc[1], 32'h4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
